jstk_poll_ctrl: RTL and testbench

Sequences periodic 40-bit transfers on the SPI master that serves the PMOD joystick. Each transfer it builds the 5-byte command frame (LED control) and fires the master's trigger. It then tracks the transfer through chip-select and decodes the 5-byte response into X/Y position and button state. It sits between the SPI master and the game logic (paddle control), so game logic never handles raw SPI frames.

---
 rtl/jstk_poll_ctrl_pkg.sv | 29 ++
 rtl/jstk_poll_ctrl_if.sv | 13 +
 rtl/jstk_poll_ctrl_poll_timer.sv | 38 +++
 rtl/jstk_poll_ctrl.sv | 174 +++++++++++++++++
 tb/tb_jstk_poll_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jstk_poll_ctrl_pkg.sv
// Shared definitions for the PMOD joystick poll controller: command frame layout,
// response byte positions and FSM encoding.
package jstk_pkg;

  localparam int JSTK_FRAME_W = 40;

  localparam logic [5:0]              JSTK_CMD_HDR = 6'b100000;
  localparam logic [JSTK_FRAME_W-1:0] JSTK_CMD_RST = 40'h80_00_00_00_00;

  // LSB positions of the response fields; the first byte received sits in [39:32]
  localparam int XL_LSB  = 32;
  localparam int XH_LSB  = 24;
  localparam int YL_LSB  = 16;
  localparam int YH_LSB  = 8;
  localparam int BTN_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_TRIG       = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_LATCH      = 3'd4
  } jstk_state_e;

  function automatic logic [JSTK_FRAME_W-1:0] jstk_build_cmd(input logic [1:0] led);
    return {JSTK_CMD_HDR, led, 32'h0000_0000};
  endfunction

endpackage

// File: rtl/jstk_poll_ctrl_if.sv
// Frame/handshake bundle between the poll controller (master modport) and the
// SPI master engine (slave modport).
interface jstk_spi_if;
  import jstk_pkg::*;

  logic                    spi_trigger;
  logic [JSTK_FRAME_W-1:0] spi_out_bytes;
  logic [JSTK_FRAME_W-1:0] spi_in_bytes;
  logic                    spi_cs;

  modport master (output spi_trigger, output spi_out_bytes, input spi_in_bytes, input spi_cs);
  modport slave  (input spi_trigger, input spi_out_bytes, output spi_in_bytes, output spi_cs);
endinterface

// File: rtl/jstk_poll_ctrl_poll_timer.sv
// Saturating up-counter: clears on clr, counts while en, stops at 'last' and
// reports expire while sitting there.
module poll_timer #(
  parameter int WIDTH = 10
) (
  input  logic             spi_clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] last,
  output logic             expire
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != last)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == last);

endmodule

// File: rtl/jstk_poll_ctrl.sv
// Periodic/on-demand poller for the PMOD joystick: issues command frames to the
// SPI master, supervises chip-select and decodes the 5-byte response.
module jstk_poll_ctrl
  import jstk_pkg::*;
#(
  parameter int POLL_PERIOD   = 1000,
  parameter int START_TIMEOUT = 8,
  parameter int DONE_TIMEOUT  = 64
) (
  input  logic       spi_clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       poll_req,
  input  logic [1:0] led,
  jstk_spi_if.master spi,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic [2:0] buttons,
  output logic       sample_valid,
  output logic       busy,
  output logic       timeout_err
);

  localparam int PW      = $clog2(POLL_PERIOD);
  localparam int TMO_MAX = (START_TIMEOUT > DONE_TIMEOUT) ? START_TIMEOUT : DONE_TIMEOUT;
  localparam int TW      = $clog2(TMO_MAX);
  localparam logic [PW-1:0] PER_LAST   = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] DONE_LAST  = TW'(DONE_TIMEOUT - 1);

  jstk_state_e             state_q, state_d;
  logic                    trig_q, trig_d;
  logic                    busy_q, busy_d;
  logic                    pend_q, pend_d;
  logic                    tmo_err_q, tmo_err_d;
  logic                    valid_q, valid_d;
  logic [9:0]              x_q, x_d;
  logic [9:0]              y_q, y_d;
  logic [2:0]              btn_q, btn_d;
  logic [JSTK_FRAME_W-1:0] cmd_q, cmd_d;

  logic          go_trig_s;
  logic          per_exp_s;
  logic          per_clr_s;
  logic          tmo_exp_s;
  logic          tmo_clr_s;
  logic [TW-1:0] tmo_last_s;
  logic          unused_in_s;

  // Period counter restarts at each trigger and idles at zero while disabled
  assign per_clr_s  = !enable || go_trig_s;
  assign tmo_clr_s  = (state_d != state_q);
  assign tmo_last_s = (state_q == ST_WAIT_START) ? START_LAST : DONE_LAST;

  poll_timer #(.WIDTH(PW)) u_period (
    .spi_clk (spi_clk),
    .reset   (reset),
    .clr     (per_clr_s),
    .en      (enable),
    .last    (PER_LAST),
    .expire  (per_exp_s)
  );

  poll_timer #(.WIDTH(TW)) u_timeout (
    .spi_clk (spi_clk),
    .reset   (reset),
    .clr     (tmo_clr_s),
    .en      (1'b1),
    .last    (tmo_last_s),
    .expire  (tmo_exp_s)
  );

  always_comb begin
    state_d   = state_q;
    go_trig_s = 1'b0;
    cmd_d     = cmd_q;
    tmo_err_d = tmo_err_q;
    x_d       = x_q;
    y_d       = y_q;
    btn_d     = btn_q;
    valid_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (poll_req || pend_q || (enable && per_exp_s)) begin
          state_d   = ST_TRIG;
          go_trig_s = 1'b1;
          cmd_d     = jstk_build_cmd(led);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TRIG: state_d = ST_WAIT_START;
      ST_WAIT_START: begin
        if (!spi.spi_cs) begin
          state_d = ST_WAIT_DONE;
        end else if (tmo_exp_s) begin
          state_d   = ST_IDLE;
          tmo_err_d = 1'b1;
        end else begin
          state_d = ST_WAIT_START;
        end
      end
      ST_WAIT_DONE: begin
        if (spi.spi_cs) begin
          state_d = ST_LATCH;
        end else if (tmo_exp_s) begin
          state_d   = ST_IDLE;
          tmo_err_d = 1'b1;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_LATCH: begin
        x_d     = {spi.spi_in_bytes[XH_LSB +: 2], spi.spi_in_bytes[XL_LSB +: 8]};
        y_d     = {spi.spi_in_bytes[YH_LSB +: 2], spi.spi_in_bytes[YL_LSB +: 8]};
        btn_d   = spi.spi_in_bytes[BTN_LSB +: 3];
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // One-deep request memory: set while a transfer is in flight, consumed by the next trigger
    if (go_trig_s) begin
      pend_d = 1'b0;
    end else if (poll_req && (state_q != ST_IDLE)) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end

    trig_d = go_trig_s;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      trig_q    <= 1'b0;
      busy_q    <= 1'b0;
      pend_q    <= 1'b0;
      tmo_err_q <= 1'b0;
      valid_q   <= 1'b0;
      x_q       <= 10'd0;
      y_q       <= 10'd0;
      btn_q     <= 3'd0;
      cmd_q     <= JSTK_CMD_RST;
    end else begin
      state_q   <= state_d;
      trig_q    <= trig_d;
      busy_q    <= busy_d;
      pend_q    <= pend_d;
      tmo_err_q <= tmo_err_d;
      valid_q   <= valid_d;
      x_q       <= x_d;
      y_q       <= y_d;
      btn_q     <= btn_d;
      cmd_q     <= cmd_d;
    end
  end

  // Response bits with no meaning for position/buttons
  assign unused_in_s = ^{spi.spi_in_bytes[31:26], spi.spi_in_bytes[15:10], spi.spi_in_bytes[7:3]};

  assign spi.spi_trigger   = trig_q;
  assign spi.spi_out_bytes = cmd_q;
  assign x_pos             = x_q;
  assign y_pos             = y_q;
  assign buttons           = btn_q;
  assign sample_valid      = valid_q;
  assign busy              = busy_q;
  assign timeout_err       = tmo_err_q;

endmodule

// File: tb/tb_jstk_poll_ctrl.sv
// Bench for jstk_poll_ctrl: SPI master model, scoreboard monitor, vector table
// and directed sequences for pending requests, timeout and mid-transfer reset.
module tb_jstk_poll_ctrl;
  localparam int PERIOD = 100;

  logic       spi_clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       poll_req = 1'b0;
  logic [1:0] led = 2'b00;
  logic [9:0] x_pos, y_pos;
  logic [2:0] buttons;
  logic       sample_valid, busy, timeout_err;

  jstk_spi_if bus();

  jstk_poll_ctrl #(.POLL_PERIOD(PERIOD), .START_TIMEOUT(8), .DONE_TIMEOUT(64)) dut (
    .spi_clk(spi_clk), .reset(reset), .enable(enable), .poll_req(poll_req), .led(led),
    .spi(bus), .x_pos(x_pos), .y_pos(y_pos), .buttons(buttons),
    .sample_valid(sample_valid), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 spi_clk = ~spi_clk;

  typedef struct {
    logic [39:0] resp;
    logic [1:0]  led;
    logic [9:0]  ex;
    logic [9:0]  ey;
    logic [2:0]  eb;
    logic [7:0]  eb0;
  } vec_t;

  int          checks = 0, errors = 0;
  int          cyc = 0, trig_cnt = 0, valid_cnt = 0, last_trig = -1, last_lat = 0;
  logic [39:0] exp_q[$];
  bit          m_mute = 1'b0, m_rand = 1'b0, chk_period = 1'b0;
  logic [39:0] m_resp = 40'd0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge spi_clk);
      #1;
    end
  endtask

  task automatic pulse_poll();
    poll_req = 1'b1;
    tick();
    poll_req = 1'b0;
  endtask

  task automatic wait_valid(input int target, input int budget, input string name);
    int n = 0;
    while (valid_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk(name, 40'(valid_cnt >= target), 40'd1);
  endtask

  task automatic wait_trig(input int target, input int budget, input string name);
    int n = 0;
    while (trig_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk(name, 40'(trig_cnt >= target), 40'd1);
  endtask

  // SPI master model: cs falls after a delay, stays low for the transfer, response appears as cs rises
  initial begin
    bus.spi_cs       = 1'b1;
    bus.spi_in_bytes = 40'd0;
    forever begin
      @(negedge spi_clk);
      if (!reset && bus.spi_trigger && !m_mute) begin
        logic [39:0] resp;
        int d, len;
        bit ab;
        resp = m_rand ? {8'($urandom), 32'($urandom)} : m_resp;
        d    = m_rand ? int'($urandom_range(4, 1)) : 2;
        len  = m_rand ? int'($urandom_range(44, 36)) : 40;
        ab   = 1'b0;
        for (int i = 0; i < d; i++) begin
          @(negedge spi_clk);
          if (reset) ab = 1'b1;
        end
        if (!ab) begin
          bus.spi_cs = 1'b0;
          for (int i = 0; i < len; i++) begin
            @(negedge spi_clk);
            if (reset) ab = 1'b1;
          end
        end
        if (!ab) begin
          bus.spi_in_bytes = resp;
          exp_q.push_back(resp);
        end
        bus.spi_cs = 1'b1;
      end
    end
  end

  // Monitor: command frame vs led, frame stability, poll interval, decoded sample vs scoreboard
  initial begin
    bit          prev_trig, prev_valid;
    logic [1:0]  led_prev;
    logic [39:0] frame_t, r;
    int          b0, b1, b2, b3, b4;
    prev_trig = 1'b0; prev_valid = 1'b0; led_prev = 2'b00; frame_t = 40'd0;
    forever begin
      @(negedge spi_clk);
      cyc++;
      if (reset) begin
        prev_trig  = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (bus.spi_trigger) begin
          trig_cnt++;
          chk("trigger_single_cycle", 40'(prev_trig), 40'd0);
          frame_t = 40'(128 + int'(led_prev)) << 32;
          chk("cmd_frame_at_trigger", bus.spi_out_bytes, frame_t);
          if (chk_period && last_trig >= 0) chk("poll_interval", 40'(cyc - last_trig), 40'(PERIOD));
          last_trig = cyc;
        end else if (busy) begin
          chk("cmd_frame_held", bus.spi_out_bytes, frame_t);
        end
        if (sample_valid) begin
          valid_cnt++;
          last_lat = cyc - last_trig;
          chk("sample_valid_single_cycle", 40'(prev_valid), 40'd0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_sample: got sample_valid=1, want no sample");
          end else begin
            r  = exp_q.pop_front();
            b0 = int'((r >> 32) & 40'hFF);
            b1 = int'((r >> 24) & 40'hFF);
            b2 = int'((r >> 16) & 40'hFF);
            b3 = int'((r >> 8) & 40'hFF);
            b4 = int'(r & 40'hFF);
            chk("model_x_pos", 40'(x_pos), 40'((b1 % 4) * 256 + b0));
            chk("model_y_pos", 40'(y_pos), 40'((b3 % 4) * 256 + b2));
            chk("model_buttons", 40'(buttons), 40'(b4 % 8));
          end
        end
        prev_trig  = bus.spi_trigger;
        prev_valid = sample_valid;
      end
      led_prev = led;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[5];
    int          t0, v0;
    logic [9:0]  xs, ys;
    logic [2:0]  bs;
    vt[0] = '{40'h34_02_C8_01_05, 2'b10, 10'h234, 10'h1C8, 3'b101, 8'h82};
    vt[1] = '{40'hFF_03_FF_03_07, 2'b11, 10'h3FF, 10'h3FF, 3'b111, 8'h83};
    vt[2] = '{40'h00_00_00_00_00, 2'b00, 10'h000, 10'h000, 3'b000, 8'h80};
    vt[3] = '{40'hAB_FD_12_FE_F2, 2'b01, 10'h1AB, 10'h212, 3'b010, 8'h81};
    vt[4] = '{40'h5A_FC_A5_00_08, 2'b10, 10'h05A, 10'h0A5, 3'b000, 8'h82};

    tick(3);
    chk("rst_trigger", 40'(bus.spi_trigger), 40'd0);
    chk("rst_out_bytes", bus.spi_out_bytes, 40'h80_00_00_00_00);
    chk("rst_x_pos", 40'(x_pos), 40'd0);
    chk("rst_y_pos", 40'(y_pos), 40'd0);
    chk("rst_buttons", 40'(buttons), 40'd0);
    chk("rst_sample_valid", 40'(sample_valid), 40'd0);
    chk("rst_busy", 40'(busy), 40'd0);
    chk("rst_timeout_err", 40'(timeout_err), 40'd0);
    reset = 1'b0;
    tick(3);

    // On-demand transfers with enable=0
    for (int i = 0; i < 5; i++) begin
      led    = vt[i].led;
      m_resp = vt[i].resp;
      v0     = valid_cnt;
      pulse_poll();
      chk("tbl_trigger_next_cycle", 40'(bus.spi_trigger), 40'd1);
      chk("tbl_cmd_byte0", 40'(bus.spi_out_bytes[39:32]), 40'(vt[i].eb0));
      wait_valid(v0 + 1, 80, "tbl_sample_valid");
      chk("tbl_latency_43_45", 40'(last_lat >= 43 && last_lat <= 45), 40'd1);
      chk("tbl_x_pos", 40'(x_pos), 40'(vt[i].ex));
      chk("tbl_y_pos", 40'(y_pos), 40'(vt[i].ey));
      chk("tbl_buttons", 40'(buttons), 40'(vt[i].eb));
      tick(5);
    end
    t0 = trig_cnt;
    tick(150);
    chk("no_trigger_when_disabled", 40'(trig_cnt), 40'(t0));

    // led changes mid-transfer must not reach the frame in flight
    led = 2'b10;
    v0  = valid_cnt;
    pulse_poll();
    led = 2'b01;
    tick(20);
    chk("led_held_mid_transfer", 40'(bus.spi_out_bytes[39:32]), 40'h82);
    wait_valid(v0 + 1, 80, "led_xfer_done");
    tick(3);
    pulse_poll();
    chk("led_next_frame", 40'(bus.spi_out_bytes[39:32]), 40'h81);
    wait_valid(v0 + 2, 80, "led_xfer2_done");
    tick(3);

    // Two requests while busy collapse into one extra transfer
    t0 = trig_cnt;
    v0 = valid_cnt;
    pulse_poll();
    tick(5);
    pulse_poll();
    tick(5);
    pulse_poll();
    wait_valid(v0 + 2, 200, "pending_second_sample");
    tick(150);
    chk("pending_trigger_count", 40'(trig_cnt), 40'(t0 + 2));
    chk("pending_sample_count", 40'(valid_cnt), 40'(v0 + 2));

    // cs never falls: start timeout
    m_mute = 1'b1;
    xs = x_pos; ys = y_pos; bs = buttons;
    v0 = valid_cnt;
    pulse_poll();
    tick(7);
    chk("timeout_not_early", 40'(timeout_err), 40'd0);
    tick(3);
    chk("timeout_err_set", 40'(timeout_err), 40'd1);
    chk("timeout_idle", 40'(busy), 40'd0);
    chk("timeout_x_kept", 40'(x_pos), 40'(xs));
    chk("timeout_y_kept", 40'(y_pos), 40'(ys));
    chk("timeout_btn_kept", 40'(buttons), 40'(bs));
    chk("timeout_no_sample", 40'(valid_cnt), 40'(v0));
    m_mute = 1'b0;
    enable = 1'b1;
    t0 = trig_cnt;
    wait_trig(t0 + 1, 120, "period_after_timeout");
    chk_period = 1'b1;
    wait_valid(v0 + 1, 80, "period_after_timeout_sample");
    chk("timeout_err_sticky", 40'(timeout_err), 40'd1);

    // Free-running with random responses, timing and led
    m_rand = 1'b1;
    v0 = valid_cnt;
    for (int i = 0; i < 1000; i++) begin
      led = 2'($urandom_range(3, 0));
      tick();
    end
    chk("random_sample_count", 40'(valid_cnt - v0 >= 9), 40'd1);

    // Asynchronous reset while the transfer is in WAIT_DONE
    begin
      int n = 0;
      while (bus.spi_cs && n < 150) begin
        tick();
        n++;
      end
      chk("cs_fell_before_reset", 40'(bus.spi_cs), 40'd0);
    end
    tick(5);
    chk_period = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_trigger", 40'(bus.spi_trigger), 40'd0);
    chk("mid_rst_out_bytes", bus.spi_out_bytes, 40'h80_00_00_00_00);
    chk("mid_rst_x_pos", 40'(x_pos), 40'd0);
    chk("mid_rst_y_pos", 40'(y_pos), 40'd0);
    chk("mid_rst_buttons", 40'(buttons), 40'd0);
    chk("mid_rst_sample_valid", 40'(sample_valid), 40'd0);
    chk("mid_rst_busy", 40'(busy), 40'd0);
    chk("mid_rst_timeout_err", 40'(timeout_err), 40'd0);
    tick(3);
    reset = 1'b0;
    last_trig = -1;
    chk_period = 1'b1;
    t0 = trig_cnt;
    v0 = valid_cnt;
    wait_trig(t0 + 2, 250, "resume_after_reset");
    wait_valid(v0 + 2, 80, "resume_samples");

    enable = 1'b0;
    chk_period = 1'b0;
    tick(100);
    chk("scoreboard_drained", 40'(exp_q.size()), 40'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
